spi_serf: RTL and testbench

SPI serf (slave) endpoint that answers the team's SPI monarch: SCLK idles high, 16-bit MSB-first frames, monarch samples MISO shortly after each SCLK rise and changes MOSI at the same time. The block runs on the system clk and oversamples SS_n/SCLK/MOSI through synchronizers. It is used both as the serf interface of on-chip register blocks and as the serf half of sensor models in the test benches. It presents a received word plus a one-cycle rdy pulse, and returns a preloaded response word on MISO.

---
 rtl/spi_serf.sv | 132 +++++++++++++
 tb/tb_spi_serf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_serf.sv
// SPI serf endpoint: SCLK idles high, 16-bit MSB-first frames, inputs oversampled on clk.
// Define SPI_SERF_FRM_ERR_EN to add the frm_err output and clr_err input for bad frame lengths.
module spi_serf #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wrt,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rdy,
  output logic        busy
`ifdef SPI_SERF_FRM_ERR_EN
  ,
  input  logic        clr_err,
  output logic        frm_err
`endif
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] ss_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   ss_prev_r;
  logic                   sclk_prev_r;
  logic [15:0]            tx_hold_r;
  logic [15:0]            shift_r;
  logic [4:0]             bit_cnt_r;
  logic                   ss_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise_s;
  logic                   ss_fall_s;
  logic                   ss_rise_s;

  assign ss_s        = ss_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign ss_fall_s   = ~ss_s & ss_prev_r;
  assign ss_rise_s   = ss_s & ~ss_prev_r;

  // MISO follows the raw select so the line is released as soon as the monarch deselects
  assign MISO = SS_n ? 1'bz : shift_r[15];

  // Synchronizers and edge history; preset high so reset release never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b1}};
      ss_prev_r   <= 1'b1;
      sclk_prev_r <= 1'b1;
    end else begin
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], SS_n};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      ss_prev_r   <= ss_s;
      sclk_prev_r <= sclk_s;
    end
  end

  // Frame state machine, shift register, tx holding register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      tx_hold_r <= 16'h0000;
      shift_r   <= 16'h0000;
      bit_cnt_r <= 5'd0;
      rx_data   <= 16'h0000;
      rdy       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (wrt) begin
        tx_hold_r <= tx_data;
      end
      case (state_r)
        IDLE: begin
          if (ss_fall_s) begin
            state_r   <= ACTIVE;
            busy      <= 1'b1;
            // A wrt landing on the select edge goes straight into this frame
            shift_r   <= wrt ? tx_data : tx_hold_r;
            bit_cnt_r <= 5'd0;
          end
        end
        ACTIVE: begin
          if (ss_rise_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            if (bit_cnt_r == 5'd16) begin
              rx_data <= shift_r;
              rdy     <= 1'b1;
            end
          end else if (sclk_rise_s) begin
            shift_r <= {shift_r[14:0], mosi_s};
            if (bit_cnt_r != 5'd31) begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SERF_FRM_ERR_EN
  // Sticky frame-length error; clr_err wins over a set in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err <= 1'b0;
    end else if (clr_err) begin
      frm_err <= 1'b0;
    end else if ((state_r == ACTIVE) && ss_rise_s && (bit_cnt_r != 5'd16)) begin
      frm_err <= 1'b1;
    end else if ((state_r == IDLE) && ss_fall_s) begin
      frm_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_serf.sv
// Self-checking bench for spi_serf: table-driven frames, corner sequences and random frames.
module tb_spi_serf;
  localparam int SP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI, wrt;
  logic        miso;
  logic [15:0] tx_data, rx_data;
  logic        rdy, busy;
`ifdef SPI_SERF_FRM_ERR_EN
  logic        clr_err, frm_err;
`endif

  int          total = 0;
  int          bad = 0;
  logic [15:0] rdy_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] model_tx, model_rx;

  spi_serf #(.SYNC_STAGES(SP)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso),
    .wrt(wrt), .tx_data(tx_data), .rx_data(rx_data), .rdy(rdy), .busy(busy)
`ifdef SPI_SERF_FRM_ERR_EN
    , .clr_err(clr_err), .frm_err(frm_err)
`endif
  );

  always #10 clk = ~clk;

  // every cycle rdy is seen high logs the word presented with it
  always @(negedge clk) if (rst_n && rdy) rdy_q.push_back(rx_data);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_wrt(input logic [15:0] v);
    wrt = 1'b1; tx_data = v;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  // monarch: drives one frame, returns the first 16 MISO samples
  task automatic frame(input logic [15:0] mosi_w, input int nbits, input int wrt_bit,
                       input logic [15:0] wrt_val, input bit wrt_fall, input int hi,
                       output logic [15:0] rd_w);
    bit busy_ok;
    busy_ok = 1'b1;
    rd_w = 16'h0000;
    SS_n = 1'b0; MOSI = mosi_w[15];
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (wrt_fall && k == SP) begin wrt = 1'b1; tx_data = wrt_val; end
      else wrt = 1'b0;
    end
    for (int b = 0; b < nbits; b++) begin
      SCLK = 1'b0; repeat (4) @(negedge clk);
      SCLK = 1'b1; @(negedge clk);
      if (b < 16) rd_w = {rd_w[14:0], miso};
      if (!busy) busy_ok = 1'b0;
      MOSI = (b < 15) ? mosi_w[14-b] : b[0];
      if (b == wrt_bit) pulse_wrt(wrt_val);
      repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    SS_n = 1'b1;
    for (int k = 1; k <= hi; k++) begin
      @(negedge clk);
      if (nbits == 16 && hi >= SP + 2 && k <= SP + 2)
        check("rdy_timing", 32'(rdy), 32'(k == SP + 1));
    end
    check("busy_in_frame", 32'(busy_ok), 32'd1);
  endtask

  task automatic settle_check(input string name);
    repeat (SP + 4) @(negedge clk);
    check({name, "_rdy_count"}, 32'(rdy_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rdy_q.size() && i < exp_q.size(); i++)
      check({name, "_rdy_word"}, 32'(rdy_q[i]), 32'(exp_q[i]));
    check({name, "_rx_data"}, 32'(rx_data), 32'(model_rx));
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
    rdy_q.delete(); exp_q.delete();
  endtask

  typedef struct {
    bit          do_pre;
    logic [15:0] pre_tx;
    logic [15:0] mosi;
    int          nbits;
    int          wrt_bit;
    logic [15:0] wrt_val;
    bit          b2b;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    bit          exp_rdy;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] rd, v, mw, em, wv;
  int          nb, wb, sel;

  initial begin
    vecs[0] = '{1'b1, 16'hA5C3, 16'h8F01, 16, -1, 16'h0000, 1'b0, 16'hA5C3, 16'h8F01, 1'b1};
    vecs[1] = '{1'b0, 16'h0000, 16'h1234, 16,  7, 16'h00FF, 1'b1, 16'hA5C3, 16'h1234, 1'b1};
    vecs[2] = '{1'b0, 16'h0000, 16'hFFFF, 16, -1, 16'h0000, 1'b0, 16'h00FF, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 16'h0F0F,  8, -1, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 16'h3C3C, 20, -1, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b0};

    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; wrt = 1'b0; tx_data = 16'h0000;
`ifdef SPI_SERF_FRM_ERR_EN
    clr_err = 1'b0;
`endif
    model_tx = 16'h0000; model_rx = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_rx", 32'(rx_data), 32'h0);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_pre) begin pulse_wrt(vecs[i].pre_tx); model_tx = vecs[i].pre_tx; end
      frame(vecs[i].mosi, vecs[i].nbits, vecs[i].wrt_bit, vecs[i].wrt_val, 1'b0,
            vecs[i].b2b ? 1 : SP + 3, rd);
      if (vecs[i].nbits == 16) check("vec_miso", 32'(rd), 32'(vecs[i].exp_miso));
      if (vecs[i].wrt_bit >= 0) model_tx = vecs[i].wrt_val;
      if (vecs[i].exp_rdy) exp_q.push_back(vecs[i].exp_rx);
      model_rx = vecs[i].exp_rx;
      if (!vecs[i].b2b) settle_check("vec");
`ifdef SPI_SERF_FRM_ERR_EN
      if (!vecs[i].b2b) check("vec_frm_err", 32'(frm_err), 32'(vecs[i].nbits != 16));
      if (i == 3) begin
        repeat (5) @(negedge clk);
        check("frm_err_sticky", 32'(frm_err), 32'd1);
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        check("frm_err_clr", 32'(frm_err), 32'd0);
      end
`endif
    end

    // SCLK activity while deselected must be ignored
    for (int i = 0; i < 10; i++) begin
      SCLK = 1'b0; repeat (3) @(negedge clk);
      SCLK = 1'b1; repeat (3) @(negedge clk);
      check("idle_sclk_busy", 32'(busy), 32'd0);
    end
`ifdef SPI_SERF_FRM_ERR_EN
    check("idle_sclk_frm_err", 32'(frm_err), 32'd1);
`endif
    settle_check("idle_sclk");
    frame(16'h5555, 16, -1, 16'h0000, 1'b0, SP + 3, rd);
    check("idle_then_frame_miso", 32'(rd), 32'(model_tx));
    exp_q.push_back(16'h5555); model_rx = 16'h5555;
    settle_check("idle_then_frame");
`ifdef SPI_SERF_FRM_ERR_EN
    check("frm_err_cleared_by_fall", 32'(frm_err), 32'd0);
`endif

    // reset in the middle of a frame
    SS_n = 1'b0; MOSI = 1'b1; repeat (6) @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      SCLK = 1'b0; repeat (4) @(negedge clk);
      SCLK = 1'b1; repeat (4) @(negedge clk);
    end
    rst_n = 1'b0; SS_n = 1'b1;
    @(negedge clk);
    check("midreset_rx", 32'(rx_data), 32'h0);
    check("midreset_rdy", 32'(rdy), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
`ifdef SPI_SERF_FRM_ERR_EN
    check("midreset_frm_err", 32'(frm_err), 32'h0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1; model_tx = 16'h0000; model_rx = 16'h0000;
    repeat (4) @(negedge clk);
    frame(16'hC0DE, 16, -1, 16'h0000, 1'b0, SP + 3, rd);
    check("postreset_miso", 32'(rd), 32'h0);
    exp_q.push_back(16'hC0DE); model_rx = 16'hC0DE;
    settle_check("postreset");

    // wrt coinciding with the synchronized select fall
    pulse_wrt(16'h7FFE);
    repeat (3) @(negedge clk);
    frame(16'h1111, 16, -1, 16'h8001, 1'b1, SP + 3, rd);
    check("bypass_word", 32'(rd), 32'h8001);
    check("bypass_first_bit", 32'(rd[15]), 32'd1);
    check("bypass_last_bit", 32'(rd[0]), 32'd1);
    model_tx = 16'h8001;
    exp_q.push_back(16'h1111); model_rx = 16'h1111;
    settle_check("bypass");

    // random frames against the reference model
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = 16'($urandom); pulse_wrt(v); model_tx = v;
      end
      mw  = 16'($urandom);
      sel = int'($urandom_range(0, 5));
      nb  = (sel == 0) ? 8 : (sel == 1) ? 17 : 16;
      wb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      wv  = 16'($urandom);
      em  = model_tx;
      if (wb >= 0) model_tx = wv;
      frame(mw, nb, wb, wv, 1'b0, SP + 3, rd);
      if (nb == 16) begin
        check("rand_miso", 32'(rd), 32'(em));
        exp_q.push_back(mw); model_rx = mw;
      end
      settle_check("rand");
`ifdef SPI_SERF_FRM_ERR_EN
      check("rand_frm_err", 32'(frm_err), 32'(nb != 16));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
